// File: rtl/wam_hit.sv
// Whac-a-mole hit judge: synchronises and debounces the player buttons, queues
// presses, judges them one per cycle against the mole lives, keeps BCD score/miss.
module wam_hit #(
  parameter int NHOLE = 8,
  parameter int LIFEW = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   tick,
  input  logic [NHOLE-1:0]       btn,
  input  logic [NHOLE*LIFEW-1:0] holes,
  output logic [NHOLE-1:0]       whack,
  output logic [7:0]             score,
  output logic [7:0]             miss,
  output logic [3:0]             streak
);

  localparam logic [NHOLE-1:0] ONE = NHOLE'(1);

  logic [NHOLE-1:0] sync1_reg, bs_reg;
  logic [NHOLE-1:0] db_reg, db_next;
  logic [NHOLE-1:0] pending_reg, whack_reg;
  logic [NHOLE-1:0] alive, rises, pick;
  logic [7:0]       score_reg, miss_reg;
  logic [3:0]       streak_reg;
  logic             sel_hit;

  // Saturating two-digit BCD increment; goes through binary so the digits stay legal.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input logic [1:0] inc);
    logic [7:0] sum, tens, units;
    sum = {4'd0, v[7:4]} * 8'd10 + {4'd0, v[3:0]} + {6'd0, inc};
    if (sum > 8'd99)
      sum = 8'd99;
    tens  = sum / 8'd10;
    units = sum % 8'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NHOLE; gi++) begin : g_btn
      logic [2:0] hist_reg;
      logic [2:0] hist_new;

      assign hist_new = {hist_reg[1:0], bs_reg[gi]};
      assign alive[gi] = |holes[LIFEW*gi +: LIFEW];
      assign db_next[gi] = !tick                ? db_reg[gi] :
                           (hist_new == 3'b111) ? 1'b1 :
                           (hist_new == 3'b000) ? 1'b0 : db_reg[gi];

      always_ff @(posedge clk) begin
        if (clr)
          hist_reg <= 3'b000;
        else if (tick)
          hist_reg <= hist_new;
      end
    end
  endgenerate

  assign rises   = db_next & ~db_reg;
  // Isolate the lowest set pending bit (two's-complement trick).
  assign pick    = pending_reg & (~pending_reg + ONE);
  assign sel_hit = |(pick & alive);

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_reg   <= '0;
      bs_reg      <= '0;
      db_reg      <= '0;
      pending_reg <= '0;
      whack_reg   <= '0;
      score_reg   <= 8'h00;
      miss_reg    <= 8'h00;
      streak_reg  <= 4'd0;
    end else begin
      sync1_reg <= btn;
      bs_reg    <= sync1_reg;
      db_reg    <= db_next;
      whack_reg <= '0;
      if (!en) begin
        pending_reg <= '0;
      end else if (pending_reg != '0) begin
        pending_reg <= (pending_reg & ~pick) | rises;
        if (sel_hit) begin
          whack_reg  <= pick;
          score_reg  <= bcd_add_sat(score_reg, (streak_reg >= 4'd2) ? 2'd2 : 2'd1);
          streak_reg <= (streak_reg == 4'd15) ? 4'd15 : streak_reg + 4'd1;
        end else begin
          miss_reg   <= bcd_add_sat(miss_reg, 2'd1);
          streak_reg <= 4'd0;
        end
      end else begin
        pending_reg <= rises;
      end
    end
  end

  assign whack  = whack_reg;
  assign score  = score_reg;
  assign miss   = miss_reg;
  assign streak = streak_reg;

endmodule

// File: tb/tb_wam_hit.sv
// Randomised bench for wam_hit against a sample-counting behavioural model.
module tb_wam_hit;

  logic        clk = 1'b0;
  logic        clr, en, tick;
  logic [7:0]  btn;
  logic [31:0] holes;
  logic [7:0]  whack, score, miss;
  logic [3:0]  streak;

  wam_hit #(.NHOLE(8), .LIFEW(4)) dut (
    .clk(clk), .clr(clr), .en(en), .tick(tick), .btn(btn), .holes(holes),
    .whack(whack), .score(score), .miss(miss), .streak(streak)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0] bq[$];
  int         ones_run[8], zeros_run[8];
  bit         db_m[8];
  bit [7:0]   pend_m, whack_m;
  int         score_m, miss_m, streak_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_step();
    logic [7:0] bs;
    bit [7:0]   rises;
    bit         ndb;
    int         sel;
    if (clr) begin
      bq = '{8'h00, 8'h00};
      for (int i = 0; i < 8; i++) begin
        ones_run[i] = 0; zeros_run[i] = 3; db_m[i] = 0;
      end
      pend_m = 0; whack_m = 0; score_m = 0; miss_m = 0; streak_m = 0;
      return;
    end
    bs = bq[bq.size()-2];
    bq.push_back(btn);
    if (bq.size() > 4) void'(bq.pop_front());
    rises = 0;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (bs[i]) begin
          ones_run[i] = (ones_run[i] < 3) ? ones_run[i] + 1 : 3; zeros_run[i] = 0;
        end else begin
          zeros_run[i] = (zeros_run[i] < 3) ? zeros_run[i] + 1 : 3; ones_run[i] = 0;
        end
        ndb = (ones_run[i] >= 3) ? 1'b1 : (zeros_run[i] >= 3) ? 1'b0 : db_m[i];
        if (ndb && !db_m[i]) rises[i] = 1;
        db_m[i] = ndb;
      end
    end
    whack_m = 0;
    if (!en) begin
      pend_m = 0;
    end else begin
      if (pend_m != 0) begin
        sel = 0;
        while (!pend_m[sel]) sel++;
        pend_m[sel] = 0;
        if (holes[4*sel +: 4] != 4'd0) begin
          whack_m[sel] = 1;
          score_m  = score_m + ((streak_m >= 2) ? 2 : 1);
          if (score_m > 99) score_m = 99;
          streak_m = (streak_m < 15) ? streak_m + 1 : 15;
        end else begin
          miss_m   = (miss_m < 99) ? miss_m + 1 : 99;
          streak_m = 0;
        end
      end
      pend_m = pend_m | rises;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_val("whack",  {24'd0, whack},  {24'd0, whack_m});
    check_val("score",  {24'd0, score},  {24'd0, to_bcd(score_m)});
    check_val("miss",   {24'd0, miss},   {24'd0, to_bcd(miss_m)});
    check_val("streak", {28'd0, streak}, 32'(streak_m));
    cyc++;
    tick = (cyc % 3 == 0);
  endtask

  function automatic logic [31:0] rand_holes();
    logic [31:0] h;
    h = 0;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(0, 1) == 1) h[4*i +: 4] = 4'($urandom_range(1, 15));
    return h;
  endfunction

  initial begin
    clr = 1; en = 1; tick = 1; btn = 8'hFF; holes = 0;
    // reset with buttons held and ticks running, then keep them held
    repeat (2) step();
    clr = 0;
    repeat (12) step();
    btn = 0;
    repeat (15) step();

    // single hit on hole 3
    holes = 32'h0000_5000; btn = 8'h08;
    repeat (15) step();
    btn = 0;
    repeat (15) step();

    // simultaneous presses on holes 0 and 5
    holes = 32'h0020_0002; btn = 8'h21;
    repeat (15) step();
    btn = 0;
    repeat (15) step();

    // random play: mixed holes, enable drops, occasional mid-queue reset
    for (int r = 0; r < 40; r++) begin
      holes = rand_holes();
      btn   = 8'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      for (int k = 0, n = $urandom_range(8, 20); k < n; k++) begin
        if ($urandom_range(0, 3) == 0) holes = rand_holes();
        clr = ($urandom_range(0, 63) == 0);
        step();
      end
      clr = 0; btn = 0;
      repeat (12) step();
    end

    // hit grind: all moles up, drive score and streak into saturation
    en = 1; holes = 32'h1111_1111;
    for (int r = 0; r < 30; r++) begin
      btn = 8'hFF; repeat (12) step();
      btn = 8'h00; repeat (12) step();
    end

    // miss grind: no moles, drive miss into saturation
    holes = 0;
    for (int r = 0; r < 15; r++) begin
      btn = 8'hFF; repeat (12) step();
      btn = 8'h00; repeat (12) step();
    end

    // bouncing button with the game stopped, then resume while still held
    en = 0; holes = 32'h0000_0300;
    for (int k = 0; k < 10; k++) begin
      btn = (k % 2 == 0) ? 8'h04 : 8'h00;
      repeat (3) step();
    end
    btn = 8'h04;
    repeat (20) step();
    en = 1;
    repeat (15) step();
    btn = 0;
    repeat (15) step();
    btn = 8'h04;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wam_hit.md
# wam_hit

Hit judge and scorer for the whac-a-mole game; sits directly downstream of the mole-life controller. Takes the per-hole mole lives and the eight raw player buttons, then synchronises and debounces the buttons and queues presses. Each queued press is judged against the current mole state. Outputs are a one-cycle whack pulse back to the controller (to retire the hit mole) and saturating BCD score and miss counters for the display stage.

## Interface
- NHOLE, 8: number of holes and buttons
- LIFEW, 4: width of one hole's mole-life field
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous, active-high reset
- en  in  1  game running; 0 freezes judging and scoring
- tick  in  1  one-cycle debounce sample strobe (about 1 kHz)
- btn  in  NHOLE  raw active-high buttons, asynchronous to clk
- holes  in  NHOLE*LIFEW  mole life of hole i on bits [LIFEW*i+LIFEW-1 : LIFEW*i]; nonzero means a mole is up
- whack  out  NHOLE  one-hot, one-cycle pulse: hole i was hit
- score  out  8  two BCD digits {tens, units}, 0..99
- miss  out  8  two BCD digits, 0..99
- streak  out  4  consecutive hits, saturates at 15

## Operation
- Sync: each btn bit passes a 2-FF synchroniser every clk, giving bs.
- Debounce (per button): on a tick cycle, hist <= {hist[1:0], bs}.
  - db[i] <= 1 when the new 3 samples are 111.
  - db[i] <= 0 when they are 000.
  - Otherwise db[i] holds.
- Press: db[i] 0->1 sets pending[i] at that same edge. A press on a hole already pending merges into it.
- Service: each cycle with en=1 and pending!=0, pick the lowest-index pending hole i, then:
  - pending <= (pending & ~onehot(i)) | new_presses.
  - Judge using holes[i] as present in the cycle before the service edge.
- Hit (holes[i]!=0):
  - whack[i] pulses.
  - Add 2 to score if the pre-hit streak >= 2, else add 1.
  - streak <= min(streak+1, 15).
- Miss (holes[i]==0):
  - miss <= min(miss+1, 99).
  - streak <= 0.
  - whack stays 0.
- BCD arithmetic:
  - Units digit wraps 9->0 and carries into tens.
  - A result above 99 saturates at 99 (e.g. 98+2 -> 99).
  - Digits are never 0xA..0xF.
- en=0:
  - pending is cleared and new presses are discarded.
  - whack stays 0; score, miss and streak hold.
  - Synchroniser and debounce keep running, so db is correct when en rises. A button already held when en rises produces no press.

## Timing
- Reset (clr=1 at an edge):
  - Registers cleared: synchronisers, hist, db, pending, whack, score, miss, streak.
  - clr overrides tick, en and all pending work.
  - clr mid-queue drops all queued presses.
- Latency: btn change -> bs after 2 edges.
- Debounce confirmation needs 3 tick samples that agree.
- Once db rises at edge E0:
  - pending is set at E0.
  - Service happens at E1 = E0+1 (if no lower-index hole is pending).
  - whack[i] is high for exactly the cycle after E1.
  - score, miss and streak are updated at E1.
- Simultaneous presses on k holes are served in index order at one hole per cycle; the last is served k-1 cycles after the first.
- A mole retired by its controller before service counts as a miss (judged at service time).
- whack is a registered, one-hot, single-cycle pulse. It is never asserted two cycles in a row for the same press.

## Test plan
- Reset: hold clr for 2 cycles with btn=0xFF and tick toggling -> all outputs 0, and no whack for 3 ticks after clr drops while btn=0xFF stays held.
- Single hit: holes[3]=5, press btn[3] for 4 ticks, en=1 -> whack=0x08 for one cycle, 1 cycle after db rise; score=0x01; streak=1.
- Miss: holes all 0, press btn[6] -> miss=0x01, streak=0, whack never set.
- Simultaneous: holes[0]=holes[5]=2, btn[0] and btn[5] rise together -> whack=0x01 then whack=0x20 on consecutive cycles; score=0x02.
- Streak bonus and saturation:
  - Three consecutive hits -> score 01, 02, 04.
  - Preload to score=0x98 by repeated hits, then one more bonus hit -> score=0x99 and stays 0x99.
- Bounce: btn[2] toggles every tick for 10 ticks, then holds 1 -> no press until 3 stable samples, then exactly one service; with en=0 throughout, no whack and counters unchanged.
